lifo_stream_reverser: RTL and testbench

Controller that sits directly upstream and downstream of the 4x4-bit LIFO buffer register and drives its push/pop/enable/reset pins. It accepts a framed stream of 4-bit words over a valid/ready handshake and pushes each word onto the stack. When a frame ends, it pops the stack and re-emits the frame in reverse order over a second valid/ready handshake. Intended use is word-order reversal of short packets ahead of the serial output stage.

---
 rtl/lifo_stream_reverser.sv | 114 +++++++++++
 tb/tb_lifo_stream_reverser.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stream_reverser.sv
// Frame reverser: pushes an input frame onto an external LIFO, then pops it
// back out word by word over a second valid/ready handshake.
module lifo_stream_reverser #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] stk_dataIn,
  output logic             stk_RW,
  output logic             stk_EN,
  output logic             stk_Rst,
  input  logic [WIDTH-1:0] stk_dataOut,
  input  logic             stk_FULL,
  input  logic             stk_EMPTY,
  output logic             frame_trunc
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_POP  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             out_valid_nxt, out_last_nxt, trunc_nxt;

  assign stk_dataIn = in_data;

  // Next-state, stack pin and output-register update logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    trunc_nxt     = 1'b0;
    in_ready      = 1'b0;
    stk_EN        = 1'b0;
    stk_RW        = 1'b0;
    stk_Rst       = 1'b0;
    case (state)
      S_INIT: begin
        stk_EN    = 1'b1;
        stk_Rst   = 1'b1;
        state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = (cnt < CNT_MAX) && !stk_FULL;
        if (in_valid && in_ready) begin
          stk_EN  = 1'b1;
          cnt_nxt = cnt + CNT_ONE;
          if (in_last || (cnt == CNT_LAST)) state_nxt = S_POP;
          trunc_nxt = (cnt == CNT_LAST) && !in_last;
        end
      end
      S_POP: begin
        // An empty stack here means the pin contract was broken; do not underflow it
        stk_EN    = !stk_EMPTY;
        stk_RW    = 1'b1;
        state_nxt = S_CAPT;
      end
      S_CAPT: begin
        out_data_nxt  = stk_dataOut;
        out_last_nxt  = (cnt == CNT_ONE);
        cnt_nxt       = cnt - CNT_ONE;
        out_valid_nxt = 1'b1;
        state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
          state_nxt     = (cnt == '0) ? S_FILL : S_POP;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_trunc <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      out_data    <= out_data_nxt;
      out_valid   <= out_valid_nxt;
      out_last    <= out_last_nxt;
      frame_trunc <= trunc_nxt;
    end
  end

endmodule

// File: tb/tb_lifo_stream_reverser.sv
// Bench for lifo_stream_reverser: behavioural LIFO, frame-level reference
// model feeding a scoreboard queue, and an output monitor.
module tb_lifo_stream_reverser;

  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic [3:0] stk_dataIn;
  logic       stk_RW, stk_EN, stk_Rst;
  logic [3:0] stk_dataOut = 4'h0;
  logic       stk_FULL, stk_EMPTY;
  logic       frame_trunc;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  lifo_stream_reverser #(.WIDTH(4), .DEPTH(4), .CW(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .stk_dataIn(stk_dataIn), .stk_RW(stk_RW), .stk_EN(stk_EN), .stk_Rst(stk_Rst),
    .stk_dataOut(stk_dataOut), .stk_FULL(stk_FULL), .stk_EMPTY(stk_EMPTY),
    .frame_trunc(frame_trunc)
  );

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural 4-deep LIFO; pins captured mid-cycle, applied at the rising edge
  logic [3:0] stk_mem[$];
  int         stk_n = 0;
  logic       s_en, s_rw, s_rst;
  logic [3:0] s_din;
  assign stk_FULL  = (stk_n == D);
  assign stk_EMPTY = (stk_n == 0);

  initial forever begin
    @(negedge Clk);
    s_en = stk_EN; s_rw = stk_RW; s_rst = stk_Rst; s_din = stk_dataIn;
  end

  initial forever begin
    @(posedge Clk);
    if (s_en && s_rst) stk_mem.delete();
    else if (s_en && !s_rw && stk_mem.size() < D) stk_mem.push_back(s_din);
    if (s_en && !s_rst && s_rw && stk_mem.size() > 0) stk_dataOut <= stk_mem.pop_back();
    else stk_dataOut <= 4'($urandom);
    stk_n <= int'(stk_mem.size());
  end

  // Reference model: frames accepted, reversed, queued; cycle timing of handshakes
  typedef struct packed { logic [3:0] d; logic l; } exp_t;
  exp_t       expq[$];
  logic [3:0] frame[$];
  bit started = 0, init_cyc = 0, draining = 0, trunc_exp = 0;
  int cd = 0, drain_left = 0;

  initial forever begin
    bit exp_valid, pop_cyc, push_cyc;
    @(negedge Clk);
    exp_valid = 0;
    if (started && init_cyc) begin
      chk("init_in_ready", int'(in_ready), 0);
      chk("init_stk_pins", int'({stk_EN, stk_RW, stk_Rst}), 'b101);
      chk("init_out_valid", int'(out_valid), 0);
      chk("init_out_last", int'(out_last), 0);
      chk("init_out_data", int'(out_data), 0);
      chk("init_frame_trunc", int'(frame_trunc), 0);
    end else if (started) begin
      if (cd != 0) cd--;
      exp_valid = draining && (cd == 0);
      pop_cyc   = draining && (cd == 2);
      push_cyc  = in_valid && !draining;
      chk("in_ready", int'(in_ready), int'(!draining));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("frame_trunc", int'(frame_trunc), int'(trunc_exp));
      if (push_cyc) begin
        chk("push_pins", int'({stk_EN, stk_RW, stk_Rst}), 'b100);
        chk("push_data", int'(stk_dataIn), int'(in_data));
      end else if (pop_cyc) chk("pop_pins", int'({stk_EN, stk_RW, stk_Rst}), 'b110);
      else chk("idle_pins", int'({stk_EN, stk_RW, stk_Rst}), 0);
    end
    if (Rst) begin
      started = 1; frame.delete(); expq.delete();
      draining = 0; cd = 0; drain_left = 0; trunc_exp = 0;
    end else if (started && !init_cyc) begin
      trunc_exp = 0;
      if (in_valid && !draining) begin
        frame.push_back(in_data);
        if (in_last || frame.size() == D) begin
          trunc_exp = !in_last;
          for (int i = int'(frame.size()) - 1; i >= 0; i--)
            expq.push_back('{d: frame[i], l: (i == 0)});
          drain_left = int'(frame.size());
          frame.delete(); draining = 1; cd = 3;
        end
      end else if (exp_valid && out_ready) begin
        drain_left--;
        if (drain_left == 0) draining = 0;
        else cd = 3;
      end
    end
    init_cyc = Rst;
  end

  // Output monitor: pops the scoreboard on each output handshake, checks hold under backpressure
  initial forever begin
    bit hold;
    logic [3:0] hold_d;
    logic hold_l;
    exp_t e;
    @(negedge Clk);
    if (Rst) hold = 0;
    else begin
      if (hold) begin
        chk("hold_data", int'(out_data), int'(hold_d));
        chk("hold_last", int'(out_last), int'(hold_l));
      end
      if (out_valid && out_ready) begin
        chk("out_expected", int'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_last", int'(out_last), int'(e.l));
        end
      end
      hold = out_valid && !out_ready; hold_d = out_data; hold_l = out_last;
    end
  end

  // Call between a rising edge + 1 and the next falling edge
  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    bit done = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!done && n < 200) begin
      @(negedge Clk); done = in_ready;
      @(posedge Clk); #1; n++;
    end
    in_valid = 0; in_last = 0;
    chk("send_accepted", int'(done), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (draining && n < 200) begin @(posedge Clk); n++; end
    chk("drain_done", int'(draining), 0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 50) begin @(negedge Clk); seen = out_valid; n++; end
    chk("valid_seen", int'(seen), 1);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 1); wait_drain();
    send(4'hA, 1); wait_drain();
    for (int i = 1; i <= 5; i++) send(4'(i), 0);
    send(4'h6, 1); wait_drain();
    // backpressure on each word of a two-word frame
    out_ready = 0;
    send(4'h7, 0); send(4'h8, 1);
    repeat (2) begin
      wait_valid();
      repeat (5) @(posedge Clk);
      #1 out_ready = 1;
      @(posedge Clk); #1 out_ready = 0;
    end
    out_ready = 1; wait_drain();
    // reset while presenting the first word of a three-word frame
    out_ready = 0;
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 1);
    wait_valid();
    @(posedge Clk); #1 Rst = 1;
    @(posedge Clk); #1 Rst = 0; out_ready = 1;
    send(4'hC, 1); wait_drain();
    for (int i = 0; i < 1500; i++) begin
      @(posedge Clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      Rst       = ($urandom_range(0, 199) == 0);
    end
    @(posedge Clk); #1;
    in_valid = 0; in_last = 0; Rst = 0; out_ready = 1;
    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
